// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: shared state encoding, frame constants and parity helper for the UART transmitter
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int FRAME_BITS           = 11;
  localparam int DEFAULT_CLKS_PER_BIT = 864;
  localparam int PAR_NONE             = 0;
  localparam int PAR_EVEN             = 1;
  localparam int PAR_ODD              = 2;

  function automatic logic parity_bit(input int mode, input logic [7:0] data);
    return mode == PAR_EVEN ? ^data : mode == PAR_ODD ? ~^data : 1'b0;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO buffering bytes ahead of the serialiser
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: buffers bytes via valid/ready and serialises them as start, 8 data LSB-first, parity, stop
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       Tx_D,
  output logic       tx_busy
);

  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t   state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          bit_end;
  logic          pop;

  assign bit_end  = baud == CW'(CLKS_PER_BIT - 1);
  // Popping at the end of STOP lets frames run back-to-back with no idle gap
  assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
  assign tx_ready = !full;
  assign tx_busy  = state != IDLE || !empty;

  uart_tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (tx_valid),
    .din   (tx_data),
    .rd_en (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      Tx_D    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= head;
            par   <= parity_bit(PARITY_MODE, head);
            state <= START;
            Tx_D  <= 1'b0;
          end
        end
        START: begin
          baud <= bit_end ? '0 : baud + CW'(1);
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            Tx_D    <= shift[0];
          end
        end
        DATA: begin
          baud <= bit_end ? '0 : baud + CW'(1);
          if (bit_end && bit_idx == 3'd7) begin
            state <= PARITY;
            Tx_D  <= par;
          end else if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= shift >> 1;
            Tx_D    <= shift[1];
          end
        end
        PARITY: begin
          baud <= bit_end ? '0 : baud + CW'(1);
          if (bit_end) begin
            state <= STOP;
            Tx_D  <= 1'b1;
          end
        end
        STOP: begin
          baud <= bit_end ? '0 : baud + CW'(1);
          if (pop) begin
            shift <= head;
            par   <= parity_bit(PARITY_MODE, head);
            state <= START;
            Tx_D  <= 1'b0;
          end else if (bit_end) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          baud  <= '0;
          Tx_D  <= 1'b1;
        end
      endcase
    end
  end

endmodule
